// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage (master)
// and instruction memory (slave).
interface if_fetch_stage_if;
   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;

   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_ready_i;
   logic            imem_rvalid_i;
   logic [ILEN-1:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_ready_i,
      input  imem_rvalid_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_ready_i,
      output imem_rvalid_i,
      output imem_rdata_i
   );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register: one outstanding imem
// request, decode stall, bubble flush and EX redirect.
module if_fetch_stage #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                stall_i,
   input  logic                flush_i,
   input  logic                redirect_i,
   input  logic [63:0]         redirect_pc_i,
   if_fetch_stage_if.master    imem,
   output logic [31:0]         inst_o,
   output logic [63:0]         pc_o,
   output logic                valid_o
);
   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            kill_q, kill_d;
   logic [ILEN-1:0] buf_q, buf_d;
   logic [ILEN-1:0] inst_d;
   logic [XLEN-1:0] pc_out_d;
   logic            valid_d;
   logic            deliver;
   logic [ILEN-1:0] deliver_data;

   assign imem.imem_req_o  = (state_q == S_REQ) & ~redirect_i & ~rst_i;
   assign imem.imem_addr_o = pc_q;

   // State, PC and IF/ID registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         kill_q  <= 1'b0;
         buf_q   <= '0;
         inst_o  <= NOP_INST;
         pc_o    <= '0;
         valid_o <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         kill_q  <= kill_d;
         buf_q   <= buf_d;
         inst_o  <= inst_d;
         pc_o    <= pc_out_d;
         valid_o <= valid_d;
      end
   end

   // Next-state, PC and IF/ID selection
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      kill_d       = kill_q;
      buf_d        = buf_q;
      deliver      = 1'b0;
      deliver_data = buf_q;
      inst_d       = inst_o;
      pc_out_d     = pc_o;
      valid_d      = valid_o;

      if (redirect_i) begin
         pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
         case (state_q)
            S_WAIT: begin
               // A response landing on the redirect edge is simply dropped;
               // otherwise the one still in flight must be killed later.
               if (imem.imem_rvalid_i) begin
                  state_d = S_REQ;
                  kill_d  = 1'b0;
               end else begin
                  kill_d  = 1'b1;
               end
            end
            S_HOLD:  state_d = S_REQ;
            default: state_d = S_REQ;
         endcase
      end else begin
         case (state_q)
            S_REQ: begin
               if (imem.imem_ready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (imem.imem_rvalid_i) begin
                  if (kill_q) begin
                     kill_d  = 1'b0;
                     state_d = S_REQ;
                  end else if (!stall_i) begin
                     deliver      = 1'b1;
                     deliver_data = imem.imem_rdata_i;
                     state_d      = S_REQ;
                  end else begin
                     buf_d   = imem.imem_rdata_i;
                     state_d = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (!stall_i) begin
                  deliver = 1'b1;
                  state_d = S_REQ;
               end
            end
            default: state_d = S_REQ;
         endcase
         if (deliver) pc_d = pc_q + XLEN'(4);
      end

      if (redirect_i || flush_i) begin
         inst_d   = NOP_INST;
         pc_out_d = pc_q;
         valid_d  = 1'b0;
      end else if (stall_i) begin
         inst_d   = inst_o;
      end else if (deliver) begin
         inst_d   = deliver_data;
         pc_out_d = pc_q;
         valid_d  = 1'b1;
      end else begin
         inst_d   = NOP_INST;
         pc_out_d = pc_q;
         valid_d  = 1'b0;
      end
   end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage against a transaction-level fetch model,
// plus directed scenarios with literal expectations.
module tb_if_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, redirect;
   logic [63:0] rpc;
   logic [31:0] inst, inst_w;
   logic [63:0] pco, pco_w;
   logic        valid, valid_w;

   if_fetch_stage_if m ();
   if_fetch_stage_if mw ();

   if_fetch_stage #(.RESET_PC(64'h0), .NOP_INST(NOP)) dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
      .redirect_i(redirect), .redirect_pc_i(rpc), .imem(m),
      .inst_o(inst), .pc_o(pco), .valid_o(valid));

   if_fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .NOP_INST(NOP)) dut_w (
      .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
      .redirect_i(redirect), .redirect_pc_i(rpc), .imem(mw),
      .inst_o(inst_w), .pc_o(pco_w), .valid_o(valid_w));

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   logic chk_en = 1'b0;

   // Memory side: instruction word is a fixed function of its address.
   int          k_lat = 1;
   logic        mem_busy = 1'b0;
   int          mem_cnt = 0;
   logic [63:0] mem_addr = '0, mem_addr_w = '0;

   // Reference model: what fetch has outstanding and what IF/ID should show.
   logic [63:0] m_pc;
   logic        m_wait, m_kill, m_hold;
   logic [31:0] m_buf;
   logic [31:0] e_inst;
   logic [63:0] e_pc;
   logic        e_valid;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      logic [31:0] h;
      case (a)
         64'h0:   h = 32'h0050_0093;
         64'h4:   h = 32'h00A0_0113;
         64'h8:   h = 32'h0020_8133;
         default: h = (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
      endcase
      return h;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 64'h0; m_wait = 0; m_kill = 0; m_hold = 0; m_buf = '0;
      e_inst = NOP; e_pc = '0; e_valid = 0;
   endtask

   // One clock edge of the fetch rules, using the inputs present before the edge.
   task automatic model_update();
      logic [63:0] old_pc;
      logic        dlv;
      logic [31:0] d;
      if (rst) return;
      old_pc = m_pc; dlv = 0; d = '0;
      if (redirect) begin
         m_pc = {rpc[63:2], 2'b00};
         if (m_wait) begin
            if (m.imem_rvalid_i) begin m_wait = 0; m_kill = 0; end
            else m_kill = 1;
         end
         m_hold = 0;
      end else if (!m_wait && !m_hold) begin
         if (m.imem_ready_i) m_wait = 1;
      end else if (m_wait) begin
         if (m.imem_rvalid_i) begin
            m_wait = 0;
            if (m_kill) m_kill = 0;
            else if (!stall) begin dlv = 1; d = m.imem_rdata_i; end
            else begin m_hold = 1; m_buf = m.imem_rdata_i; end
         end
      end else if (!stall) begin
         dlv = 1; d = m_buf; m_hold = 0;
      end
      if (dlv) m_pc = old_pc + 64'd4;
      if (redirect || flush) begin e_inst = NOP; e_pc = old_pc; e_valid = 0; end
      else if (stall) begin end
      else if (dlv) begin e_inst = d; e_pc = old_pc; e_valid = 1; end
      else begin e_inst = NOP; e_pc = old_pc; e_valid = 0; end
   endtask

   // Advance one cycle: memory acceptance, model step, then memory response drive.
   task automatic tick();
      logic        acc;
      logic [63:0] a, aw;
      @(negedge clk);
      acc = m.imem_req_o & m.imem_ready_i;
      a   = m.imem_addr_o;
      aw  = mw.imem_addr_o;
      @(posedge clk);
      model_update();
      if (m.imem_rvalid_i) mem_busy = 0;
      if (acc) begin mem_busy = 1; mem_cnt = k_lat; mem_addr = a; mem_addr_w = aw; end
      #1;
      m.imem_rvalid_i  = 0;
      mw.imem_rvalid_i = 0;
      if (mem_busy) begin
         mem_cnt--;
         if (mem_cnt == 0) begin
            m.imem_rvalid_i  = 1; m.imem_rdata_i  = mem_word(mem_addr);
            mw.imem_rvalid_i = 1; mw.imem_rdata_i = mem_word(mem_addr_w);
         end
      end
   endtask

   task automatic set_ready(input logic r);
      m.imem_ready_i = r; mw.imem_ready_i = r;
   endtask

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("req",   64'(m.imem_req_o), 64'((!m_wait && !m_hold) && !redirect && !rst));
         chk("addr",  m.imem_addr_o, m_pc);
         chk("inst",  64'(inst), 64'(e_inst));
         chk("pc_o",  pco, e_pc);
         chk("valid", 64'(valid), 64'(e_valid));
      end
   end

   initial begin
      rst = 1; stall = 0; flush = 0; redirect = 0; rpc = '0;
      set_ready(0);
      m.imem_rvalid_i = 0; m.imem_rdata_i = '0;
      mw.imem_rvalid_i = 0; mw.imem_rdata_i = '0;
      model_reset();
      #12;
      chk("rst_req",    64'(m.imem_req_o), 64'h0);
      chk("rst_addr",   m.imem_addr_o, 64'h0);
      chk("rst_inst",   64'(inst), 64'(NOP));
      chk("rst_valid",  64'(valid), 64'h0);
      chk("rst_addr_w", mw.imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
      @(posedge clk); #1;
      rst = 0; set_ready(1); chk_en = 1;

      // Back-to-back fetch with 1-cycle memory; wrap of the high RESET_PC instance
      tick(); tick();
      chk("t1_inst0",  64'(inst), 64'h0050_0093);
      chk("t1_pc0",    pco, 64'h0);
      chk("t1_v0",     64'(valid), 64'h1);
      chk("t1_addr4",  m.imem_addr_o, 64'h4);
      chk("t5_pc_w",   pco_w, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("t5_v_w",    64'(valid_w), 64'h1);
      chk("t5_inst_w", 64'(inst_w), 64'(mem_word(64'hFFFF_FFFF_FFFF_FFFC)));
      chk("t5_addr_w", mw.imem_addr_o, 64'h0);
      chk("t5_req_w",  64'(mw.imem_req_o), 64'h1);
      tick();
      chk("t1_gap", 64'(valid), 64'h0);
      tick();
      chk("t1_inst1", 64'(inst), 64'h00A0_0113);
      chk("t1_pc1",   pco, 64'h4);

      // Stall across the response: held in buffer, released exactly once
      stall = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_hold_inst", 64'(inst), 64'h00A0_0113);
         chk("t2_hold_pc",   pco, 64'h4);
      end
      stall = 0; k_lat = 3;
      tick();
      chk("t2_inst", 64'(inst), 64'h0020_8133);
      chk("t2_pc",   pco, 64'h8);
      chk("t2_addr", m.imem_addr_o, 64'hC);
      tick();
      chk("t2_once", 64'(valid), 64'h0);

      // Redirect while waiting; the late response is killed
      redirect = 1; rpc = 64'h8000_0102;
      tick();
      redirect = 0; k_lat = 1;
      chk("t3_valid", 64'(valid), 64'h0);
      chk("t3_addr",  m.imem_addr_o, 64'h8000_0100);
      tick(); tick();
      chk("t3_killed", 64'(inst), 64'(NOP));
      tick(); tick();
      chk("t3_inst", 64'(inst), 64'(mem_word(64'h8000_0100)));
      chk("t3_pc",   pco, 64'h8000_0100);

      // Flush with stall over a valid instruction
      flush = 1; stall = 1;
      tick();
      flush = 0; stall = 0;
      chk("t4_inst",  64'(inst), 64'(NOP));
      chk("t4_valid", 64'(valid), 64'h0);
      chk("t4_addr",  m.imem_addr_o, 64'h8000_0104);
      tick();

      // Asynchronous reset mid-wait; stale response afterwards is ignored
      k_lat = 3;
      tick();
      #2 rst = 1; model_reset();
      #1;
      chk("t6_req",   64'(m.imem_req_o), 64'h0);
      chk("t6_addr",  m.imem_addr_o, 64'h0);
      chk("t6_inst",  64'(inst), 64'(NOP));
      chk("t6_pc",    pco, 64'h0);
      chk("t6_valid", 64'(valid), 64'h0);
      set_ready(0);
      tick();
      rst = 0;
      tick(); tick();
      chk("t6_stale", 64'(valid), 64'h0);
      chk("t6_req1",  64'(m.imem_req_o), 64'h1);
      chk("t6_addr1", m.imem_addr_o, 64'h0);
      set_ready(1); k_lat = 1;
      tick(); tick();
      chk("t6_inst1", 64'(inst), 64'h0050_0093);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         stall    = ($urandom_range(0, 99) < 30);
         flush    = ($urandom_range(0, 99) < 8);
         redirect = ($urandom_range(0, 99) < 7);
         rpc      = {$urandom(), $urandom()};
         if ($urandom_range(0, 3) == 0) rpc[63:8] = '1;
         set_ready($urandom_range(0, 99) < 70);
         k_lat    = int'($urandom_range(1, 3));
         tick();
      end

      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
